// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT front-end constants and bank-state type
package fft_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_INTEGER = 4;
    localparam int DEF_FRACTION = 4;
    localparam int DEF_N_POINTS = 32;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_N_POINTS);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: N_POINTS x DATA_WIDTH register file with indexed write and flattened read
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_POINTS = DEF_N_POINTS,
    localparam int AW = $clog2(N_POINTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           we,
    input  logic [AW-1:0]                  idx,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [N_POINTS*DATA_WIDTH-1:0] rd_data
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) rd_data <= '0;
        else if (clear) rd_data <= '0;
        else if (we) rd_data[idx*DATA_WIDTH +: DATA_WIDTH] <= din;
endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: serial-to-parallel ping-pong framer feeding the first radix-2 stage
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INTEGER = DEF_INTEGER,
    parameter int FRACTION = DEF_FRACTION,
    parameter int N_POINTS = DEF_N_POINTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_last,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [N_POINTS*DATA_WIDTH-1:0] frame_data,
    output logic                           sync_err,
    output logic [7:0]                     frame_cnt
);
    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

    if (INTEGER + FRACTION != DATA_WIDTH) begin : g_fmt_check
        $error("INTEGER + FRACTION must equal DATA_WIDTH");
    end

    bank_state_t st [2];
    logic [AW-1:0] wr_ptr;
    logic fill_bank, rd_bank, ready_en;
    logic acc, at_last, bad, done, consume;
    logic [N_POINTS*DATA_WIDTH-1:0] bank_data [2];

    assign s_ready = ready_en && st[fill_bank] != FULL;
    assign acc = s_valid && s_ready;
    assign at_last = wr_ptr == LAST;
    assign bad = acc && s_last && !at_last;
    assign done = acc && at_last;
    assign consume = frame_valid && frame_ready;
    assign frame_data = bank_data[rd_bank];

    // on consume, frame_valid follows the other bank so a waiting frame follows without a bubble
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int b = 0; b < 2; b++) st[b] <= EMPTY;
            wr_ptr <= '0;
            fill_bank <= 1'b0;
            rd_bank <= 1'b0;
            ready_en <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++)
                if (consume && rd_bank == 1'(b)) st[b] <= EMPTY;
                else if (acc && fill_bank == 1'(b)) st[b] <= bad ? EMPTY : at_last ? FULL : FILLING;
            if (acc) wr_ptr <= (at_last || bad) ? '0 : wr_ptr + AW'(1);
            fill_bank <= fill_bank ^ done;
            rd_bank <= rd_bank ^ consume;
            ready_en <= 1'b1;
            frame_valid <= consume ? st[!rd_bank] == FULL : st[rd_bank] == FULL;
            frame_cnt <= frame_cnt + 8'(consume);
            sync_err <= bad;
        end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N_POINTS(N_POINTS)) u_bank (
            .clk(clk),
            .reset(reset),
            .clear(consume && rd_bank == 1'(g)),
            .we(acc && fill_bank == 1'(g)),
            .idx(wr_ptr),
            .din(s_data),
            .rd_data(bank_data[g])
        );
    end
endmodule

// File: doc/fft_input_framer.md
Name: fft_input_framer

Overview:
- Upstream neighbour of the radix-2 first butterfly stage.
- Accepts real fixed-point samples serially through a valid/ready handshake and assembles them into 32-sample frames.
- Presents each frame as one parallel, flattened bus, held stable until the first stage acknowledges it.
- Ping-pong double-buffered: one frame can fill while the previous one is held for the stage.

Parameters:
- DATA_WIDTH, 8, sample width in bits (signed two's complement).
- INTEGER, 4, integer bits of the fixed-point format; pass-through only, no arithmetic.
- FRACTION, 4, fraction bits; INTEGER+FRACTION must equal DATA_WIDTH.
- N_POINTS, 32, samples per frame; power of two, 2..32.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  framer can accept a sample.
- s_data  in  DATA_WIDTH  input sample (real part only).
- s_last  in  1  marks the last sample of a frame.
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  downstream stage consumes the frame.
- frame_data  out  N_POINTS*DATA_WIDTH  sample k at [k*DATA_WIDTH +: DATA_WIDTH], natural order.
- sync_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  8  count of frames delivered, wraps 255->0.

Behaviour:
- Reset (reset=0, async):
  - Both banks EMPTY, write pointer 0, fill bank 0, read bank 0.
  - s_ready=0 while reset is asserted; s_ready=1 from the first clk after release.
  - frame_valid=0, frame_data=0, sync_err=0, frame_cnt=0.
- Bank states: EMPTY -> FILLING (first accepted sample) -> FULL (sample index N_POINTS-1 accepted) -> EMPTY (frame consumed).
- Input acceptance:
  - A sample is accepted when s_valid && s_ready.
  - It is written to fill_bank[wr_ptr], and wr_ptr increments.
  - At wr_ptr = N_POINTS-1: wr_ptr wraps to 0, the bank goes FULL, and the fill bank toggles.
  - s_ready = fill bank not FULL. Both banks FULL -> s_ready=0; no sample is ever dropped or overwritten.
- Output:
  - frame_valid = read bank FULL, registered.
  - Latency: last sample accepted at edge t -> frame_valid=1 and frame_data valid after edge t+1.
  - frame_data is driven from the read bank and stays stable while frame_valid=1 && frame_ready=0.
  - On frame_valid && frame_ready: read bank -> EMPTY, read bank toggles, frame_cnt increments.
  - If the other bank is already FULL, frame_valid stays 1 and the next frame appears the following cycle (back-to-back, no bubble).
- Simultaneous events: the last sample filling a bank and the consumption of the other bank in the same edge are both honoured. The next cycle has one bank FULL and s_ready=1.
- Framing rules:
  - s_last accepted with wr_ptr != N_POINTS-1: the partial frame is discarded, wr_ptr -> 0, the bank returns to EMPTY, and sync_err pulses for 1 cycle.
  - s_last=0 on index N_POINTS-1: the frame still completes, no error (s_last is optional).
- Reset asserted mid-frame or mid-hold: all state is cleared immediately; partial and held frames are lost.
- No arithmetic, no scaling: samples are passed bit-exact.

Decomposition:
- Shared package fft_pkg:
  - N_POINTS and ADDR_WIDTH = $clog2(N_POINTS).
  - Bank-state enum {EMPTY, FILLING, FULL}.
  - Fixed-point format constants (DATA_WIDTH/INTEGER/FRACTION defaults).
- One sub-module, fft_frame_bank: an N_POINTS x DATA_WIDTH register file with write enable/index, a flattened read bus, and a clear.
  - Instantiated twice.
  - The framer owns the pointers, bank-state FSMs and handshake.

Test Plan:
- Reset release, feed samples 0..31 (value = index) with frame_ready=0 -> frame_valid=1 one cycle after the 32nd accept; frame_data[k]=k; data held stable for 10 cycles.
- Continue feeding 32 more samples (32+k) with frame_ready=0 -> second bank fills; then s_ready=0; a 65th s_valid is not accepted; frame_cnt=0.
- Pulse frame_ready once -> frame_cnt=1; next cycle frame_data[k]=32+k with frame_valid still 1; s_ready returns to 1.
- Stream continuously with frame_ready=1 and s_valid=1 every cycle -> one frame every 32 cycles, no stalls, frame_cnt increments by 1 per frame.
- s_last asserted on sample index 9 -> sync_err=1 for exactly one cycle; the next 32 samples (100+k) form a frame with frame_data[0]=100.
- Assert reset at sample index 17, then release -> frame_valid=0, frame_cnt=0; the next frame starts at index 0.
